lgn_frame_streamer: RTL
=======================

Name: lgn_frame_streamer

Overview:
- Host-side transmitter for the lgn pixel-load interface. That interface is an 8-bit data bus qualified by a single-cycle write_enable strobe, plus a 16-bit result bus.
- Accepts image bytes over a valid/ready stream and drives write_enable/data beats into lgn, one byte per accepted beat.
- After the last byte of a frame, waits a fixed settle latency, then captures the 16-bit lgn result.
- Presents the captured result on a valid/ready result port and sits between the test/host interface logic and the lgn core.

Parameters:
FRAME_BYTES, 98, bytes per frame (28x28 binary pixels packed 8 per byte); must be >= 1
SETTLE_CYCLES, 4, clocks from the last write beat to result capture; must be >= 1
CNT_W, 8, width of the completed-frame counter

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
s_data  input  8  pixel byte from upstream
s_valid  input  1  s_data valid
s_ready  output  1  streamer accepts s_data this cycle
lgn_we  output  1  write_enable to lgn, one cycle per byte
lgn_data  output  8  byte to lgn ui_in
lgn_result  input  16  lgn uo_out
r_data  output  16  captured result
r_valid  output  1  result valid
r_ready  input  1  downstream accepts result
abort  input  1  synchronous frame abort
busy  output  1  high in any state other than IDLE
frames_done  output  CNT_W  count of completed results handed off (r_valid & r_ready)

Behaviour:
- Reset values (rst_n low at posedge): state=IDLE, s_ready=0, lgn_we=0, lgn_data=0, r_data=0, r_valid=0, busy=0, frames_done=0, byte counter=0, settle counter=0. Reset overrides every other input, including mid-frame; no partial result is ever produced.
- States: IDLE, STREAM, SETTLE, HOLD.
- IDLE:
  - s_ready=1.
  - On s_valid & s_ready: register s_data into lgn_data, pulse lgn_we next cycle, byte_cnt=1, go to STREAM.
  - If FRAME_BYTES==1, go directly to SETTLE instead.
- STREAM:
  - s_ready=1. Each accepted beat registers lgn_data<=s_data and lgn_we<=1 for exactly the following cycle (one-cycle latency input to pin), then byte_cnt++.
  - No accepted beat: lgn_we=0 and lgn_data holds its value. Gaps are allowed and invisible to lgn.
  - When the accepted beat makes byte_cnt==FRAME_BYTES: s_ready drops to 0 from the next cycle, settle_cnt=0, go to SETTLE.
- SETTLE:
  - s_ready=0. The last lgn_we pulse occurs in the first SETTLE cycle. settle_cnt increments every cycle.
  - When settle_cnt==SETTLE_CYCLES: r_data<=lgn_result, r_valid<=1, go to HOLD.
  - Capture happens SETTLE_CYCLES clocks after the final lgn_we-high cycle.
- HOLD:
  - r_valid=1; r_data stable until the handshake.
  - On r_ready: r_valid<=0, frames_done<=frames_done+1 (wraps modulo 2^CNT_W), go to IDLE.
  - s_ready=0 throughout HOLD: no overlap of the next frame with an undelivered result.
- abort:
  - Sampled every cycle; has priority over all transitions except reset.
  - In STREAM or SETTLE: go to IDLE, byte_cnt=0, lgn_we=0 next cycle, no result, frames_done unchanged. A beat offered in the same cycle as abort is not accepted (s_ready forced 0 that cycle).
  - In HOLD: ignored. The result remains deliverable.
- frames_done counts only delivered results.
- busy = (state!=IDLE).
- Simultaneous r_ready and s_valid in HOLD: result is delivered; the byte is not accepted until the following IDLE cycle.

Test Plan:
- Back-to-back frame: FRAME_BYTES=98, SETTLE_CYCLES=4, s_valid held high with bytes 0x00..0x61, lgn_result=16'hBEEF, r_ready=1.
  -> 98 consecutive lgn_we pulses carrying 0x00..0x61 in order; r_valid rises exactly 5 clocks after the last lgn_we-high cycle with r_data=16'hBEEF; frames_done=1.
- Gapped input: s_valid toggling 1,0,0,1...
  -> lgn_we high only on cycles after accepted beats; lgn_data holds during gaps; exactly 98 pulses; result captured with correct timing.
- Backpressure: r_ready=0 for 10 cycles after r_valid, with s_valid=1.
  -> r_data stable, s_ready=0, no lgn_we pulses; on r_ready=1, frames_done increments by 1 and the next frame's first byte is accepted the following cycle.
- Abort at byte 50, then a full frame.
  -> no r_valid for the aborted frame; frames_done unchanged; the next frame needs all 98 bytes (98 lgn_we pulses) before r_valid.
- Reset mid-SETTLE (rst_n=0 for one cycle).
  -> all outputs at reset values on the next cycle, frames_done=0, no r_valid.
- Counter wrap: CNT_W=2, 5 frames delivered.
  -> frames_done sequence 1,2,3,0,1.

Source files
------------

// File: rtl/lgn_frame_streamer.sv
// lgn_frame_streamer: streams frame bytes into the lgn pixel-load port,
// waits out the settle latency, then hands the captured result downstream.
module lgn_frame_streamer #(
   parameter int FRAME_BYTES   = 98,
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             lgn_we,
   output logic [7:0]       lgn_data,
   input  logic [15:0]      lgn_result,
   output logic [15:0]      r_data,
   output logic             r_valid,
   input  logic             r_ready,
   input  logic             abort,
   output logic             busy,
   output logic [CNT_W-1:0] frames_done
);

   localparam int BW = $clog2(FRAME_BYTES + 1);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, STREAM, SETTLE, HOLD} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [BW-1:0] r_byte_cnt;
   logic [SW-1:0] r_settle_cnt;
   logic          w_accept;
   logic          w_last;
   logic          w_cap;

   assign s_ready  = rst_n & ~abort & ((r_state == IDLE) | (r_state == STREAM));
   assign w_accept = s_valid & s_ready;
   assign w_last   = (r_byte_cnt == BW'(FRAME_BYTES - 1));
   assign w_cap    = (r_settle_cnt == SW'(SETTLE_CYCLES));
   assign busy     = (r_state != IDLE);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_accept) w_next = w_last ? SETTLE : STREAM;
         end
         STREAM: begin
            if (abort) w_next = IDLE;
            else if (w_accept && w_last) w_next = SETTLE;
         end
         SETTLE: begin
            if (abort) w_next = IDLE;
            else if (w_cap) w_next = HOLD;
         end
         HOLD: begin
            if (r_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_byte_cnt   <= '0;
         r_settle_cnt <= '0;
         lgn_we       <= 1'b0;
         lgn_data     <= '0;
         r_data       <= '0;
         r_valid      <= 1'b0;
         frames_done  <= '0;
      end else begin
         r_state <= w_next;
         lgn_we  <= w_accept;
         if (w_accept) lgn_data <= s_data;

         if (w_next == STREAM && w_accept) r_byte_cnt <= r_byte_cnt + BW'(1);
         else if (w_next != STREAM) r_byte_cnt <= '0;

         // counter restarts at 0 on SETTLE entry, so capture lands on count==SETTLE_CYCLES
         if (r_state == SETTLE && !w_cap) r_settle_cnt <= r_settle_cnt + SW'(1);
         else r_settle_cnt <= '0;

         if (r_state == SETTLE && !abort && w_cap) begin
            r_data  <= lgn_result;
            r_valid <= 1'b1;
         end

         if (r_state == HOLD && r_ready) begin
            r_valid     <= 1'b0;
            frames_done <= frames_done + CNT_W'(1);
         end
      end
   end

endmodule
